// File: rtl/i2s_pkg.sv
// Shared types and widths for the I2S/TDM word-select generator.
// Mode encoding matches the cfg_mode_i field; value 3 is reserved.
package i2s_pkg;

    typedef enum logic [1:0] {
        WS_HALF  = 2'd0,
        WS_PULSE = 2'd1,
        WS_SLOT  = 2'd2
    } ws_mode_e;

    localparam int WORD_W = 5;

endpackage

// File: rtl/i2s_tdm_ws_gen.sv
// I2S/TDM word-select generator: bit/slot counters on the rising edge,
// WS shaped from the next position and registered on the falling edge.
module i2s_tdm_ws_gen
    import i2s_pkg::*;
#(
    parameter int MAX_SLOTS = 8,
    parameter int SLOT_W    = $clog2(MAX_SLOTS)
) (
    input  logic              sck_i,
    input  logic              rstn_i,
    input  logic              cfg_en_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [WORD_W-1:0] cfg_word_size_i,
    input  logic [SLOT_W-1:0] cfg_slots_i,
    input  logic              cfg_ws_pol_i,
    output logic              ws_o,
    output logic [WORD_W-1:0] bit_cnt_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              frame_start_o,
    output logic              word_last_o
);

    logic              run_q;
    logic [WORD_W-1:0] bit_q;
    logic [SLOT_W-1:0] slot_q;
    logic [1:0]        mode_q;
    logic [WORD_W-1:0] wsz_q;
    logic [SLOT_W-1:0] slots_q;
    logic              pol_q;
    logic              tog_q;
    logic              ws_q;

    logic              word_end;
    logic              frame_end;
    logic [WORD_W-1:0] bit_nx;
    logic [SLOT_W-1:0] slot_nx;
    logic [SLOT_W:0]   half_n;
    logic [SLOT_W:0]   half_th;
    logic              legacy;
    logic              act;
    logic              tog_nx;
    logic              ws_nx;

    assign word_end  = (bit_q == wsz_q);
    assign frame_end = word_end && (slot_q == slots_q);

    // Position the counters will hold after the next rising edge
    always_comb begin
        bit_nx  = bit_q + WORD_W'(1);
        slot_nx = slot_q;
        if (word_end) begin
            bit_nx  = '0;
            slot_nx = frame_end ? '0 : slot_q + SLOT_W'(1);
        end
    end

    // Counters, running flag and shadow config
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            run_q   <= 1'b0;
            bit_q   <= '0;
            slot_q  <= '0;
            mode_q  <= '0;
            wsz_q   <= '0;
            slots_q <= '0;
            pol_q   <= 1'b0;
        end else if (!cfg_en_i || !run_q) begin
            // stopped, or the enabling edge that holds position 0
            run_q   <= cfg_en_i;
            bit_q   <= '0;
            slot_q  <= '0;
            mode_q  <= cfg_mode_i;
            wsz_q   <= cfg_word_size_i;
            slots_q <= cfg_slots_i;
            pol_q   <= cfg_ws_pol_i;
        end else begin
            bit_q  <= bit_nx;
            slot_q <= slot_nx;
            if (frame_end) begin
                mode_q  <= cfg_mode_i;
                wsz_q   <= cfg_word_size_i;
                slots_q <= cfg_slots_i;
                pol_q   <= cfg_ws_pol_i;
            end
        end
    end

    assign half_n  = {1'b0, slots_q} + (SLOT_W + 1)'(1);
    assign half_th = half_n >> 1;
    assign legacy  = (mode_q != WS_PULSE) && (mode_q != WS_SLOT)
                  && (slots_q == '0);

    // Active WS level for the lookahead position
    always_comb begin
        act = 1'b0;
        unique case (1'b1)
            (mode_q == WS_PULSE): act = (bit_nx == '0) && (slot_nx == '0);
            (mode_q == WS_SLOT):  act = (slot_nx == '0);
            default:              act = ({1'b0, slot_nx} >= half_th);
        endcase
    end

    // Single-slot HALF keeps the old two-channel toggle behaviour
    always_comb begin
        tog_nx = tog_q ^ (run_q && word_end && legacy);
        if (legacy) begin
            ws_nx = tog_nx ^ pol_q;
        end else if (!run_q) begin
            ws_nx = pol_q;
        end else begin
            ws_nx = act ^ pol_q;
        end
    end

    // WS leads data by one bit, so it is launched on the falling edge
    always_ff @(negedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ws_q  <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            ws_q  <= ws_nx;
            tog_q <= tog_nx;
        end
    end

    assign ws_o          = ws_q;
    assign bit_cnt_o     = bit_q;
    assign slot_o        = slot_q;
    assign frame_start_o = run_q && (bit_q == '0) && (slot_q == '0);
    assign word_last_o   = run_q && word_end;

endmodule

// File: tb/tb_i2s_tdm_ws_gen.sv
// Scoreboard bench for i2s_tdm_ws_gen: stimulus queues expected
// counter/WS values, two monitors pop them on each clock edge.
module tb_i2s_tdm_ws_gen;
    import i2s_pkg::*;

    logic       sck = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [4:0] wsz = 5'd0;
    logic [2:0] slots = 3'd0;
    logic       pol = 1'b0;

    logic       ws;
    logic [4:0] bit_cnt;
    logic [2:0] slot;
    logic       fs;
    logic       wl;

    logic [1:0] st_mode = 2'd0;
    logic [4:0] st_wsz = 5'd0;
    logic [2:0] st_slots = 3'd0;
    logic       st_pol = 1'b0;

    typedef struct {
        int         tag;
        logic [4:0] b;
        logic [2:0] s;
        logic       fs;
        logic       wl;
    } cnt_t;

    typedef struct {
        int   tag;
        logic ws;
    } ws_t;

    cnt_t cq[$];
    ws_t  wq[$];
    int   checks = 0;
    int   errors = 0;

    i2s_tdm_ws_gen #(.MAX_SLOTS(8)) dut (
        .sck_i          (sck),
        .rstn_i         (rstn),
        .cfg_en_i       (en),
        .cfg_mode_i     (mode),
        .cfg_word_size_i(wsz),
        .cfg_slots_i    (slots),
        .cfg_ws_pol_i   (pol),
        .ws_o           (ws),
        .bit_cnt_o      (bit_cnt),
        .slot_o         (slot),
        .frame_start_o  (fs),
        .word_last_o    (wl)
    );

    always #5 sck = ~sck;

    task automatic chk(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s test%0d got %0h want %0h @%0t",
                     nm, tag, act, exp, $time);
        end
    endtask

    function automatic cnt_t pos(input int idx, input int w, input int n);
        cnt_t r;
        r.tag = 0;
        r.b   = 5'(idx % w);
        r.s   = 3'((idx / w) % n);
        r.fs  = ((idx % (w * n)) == 0);
        r.wl  = ((idx % w) == (w - 1));
        return r;
    endfunction

    function automatic cnt_t zero();
        cnt_t r;
        r.tag = 0;
        r.b   = 5'd0;
        r.s   = 3'd0;
        r.fs  = 1'b0;
        r.wl  = 1'b0;
        return r;
    endfunction

    task automatic step(input logic e, input int tag,
                        input cnt_t c, input int w);
        ws_t x;
        @(negedge sck);
        #2;
        en    = e;
        mode  = st_mode;
        wsz   = st_wsz;
        slots = st_slots;
        pol   = st_pol;
        c.tag = tag;
        cq.push_back(c);
        x.tag = tag;
        x.ws  = (w != 0);
        wq.push_back(x);
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [4:0] w,
                           input logic [2:0] s, input logic p);
        st_mode  = m;
        st_wsz   = w;
        st_slots = s;
        st_pol   = p;
    endtask

    // counter/decode monitor, just after the rising edge
    initial forever begin
        cnt_t e;
        @(posedge sck);
        #1;
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("bit_cnt", e.tag, 32'(bit_cnt), 32'(e.b));
            chk("slot", e.tag, 32'(slot), 32'(e.s));
            chk("frame_start", e.tag, 32'(fs), 32'(e.fs));
            chk("word_last", e.tag, 32'(wl), 32'(e.wl));
        end
    end

    // WS monitor, just after the falling edge
    initial forever begin
        ws_t e;
        @(negedge sck);
        #1;
        if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("ws", e.tag, 32'(ws), 32'(e.ws));
        end
    end

    initial begin
        #12;
        chk("rst_ws", 0, 32'(ws), 32'd0);
        chk("rst_bit", 0, 32'(bit_cnt), 32'd0);
        chk("rst_slot", 0, 32'(slot), 32'd0);
        chk("rst_fs", 0, 32'(fs), 32'd0);
        chk("rst_wl", 0, 32'(wl), 32'd0);
        @(negedge sck);
        #2;
        rstn = 1'b1;

        // HALF, two 16-bit slots
        set_cfg(2'd0, 5'd15, 3'd1, 1'b0);
        repeat (2) step(1'b0, 1, zero(), 0);
        for (int j = 0; j < 70; j++)
            step(1'b1, 1, pos(j, 16, 2), ((j + 1) / 16) % 2);

        // PULSE, eight 32-bit slots
        set_cfg(2'd1, 5'd31, 3'd7, 1'b0);
        repeat (2) step(1'b0, 2, zero(), 0);
        for (int j = 0; j < 520; j++)
            step(1'b1, 2, pos(j, 32, 8), int'(((j + 1) % 256) == 0));

        // SLOT, four 8-bit slots, active-low
        set_cfg(2'd2, 5'd7, 3'd3, 1'b1);
        repeat (2) step(1'b0, 3, zero(), 1);
        for (int j = 0; j < 70; j++)
            step(1'b1, 3, pos(j, 8, 4), int'((((j + 1) / 8) % 4) != 0));

        // word size change mid-frame takes effect at the next frame
        set_cfg(2'd0, 5'd15, 3'd1, 1'b0);
        repeat (2) step(1'b0, 4, zero(), 0);
        for (int j = 0; j < 128; j++) begin
            int k;
            if (j == 22) st_wsz = 5'd23;
            k = j + 1;
            step(1'b1, 4,
                 (j < 32) ? pos(j, 16, 2) : pos(j - 32, 24, 2),
                 (k < 32) ? (k / 16) % 2 : ((k - 32) / 24) % 2);
        end

        // stop at slot 2 bit 9, restart after five clocks
        set_cfg(2'd0, 5'd15, 3'd3, 1'b0);
        repeat (2) step(1'b0, 5, zero(), 0);
        for (int j = 0; j < 42; j++)
            step(1'b1, 5, pos(j, 16, 4), int'(((j + 1) / 16) % 4 >= 2));
        repeat (5) step(1'b0, 5, zero(), 0);
        for (int j = 0; j < 40; j++)
            step(1'b1, 5, pos(j, 16, 4), int'(((j + 1) / 16) % 4 >= 2));

        // single 1-bit slot: WS toggles every bit
        set_cfg(2'd0, 5'd0, 3'd0, 1'b0);
        repeat (2) step(1'b0, 6, zero(), 0);
        for (int j = 0; j < 19; j++)
            step(1'b1, 6, pos(j, 1, 1), (j + 1) % 2);

        @(negedge sck);
        #3;
        chk("pre_rst_ws", 6, 32'(ws), 32'd1);
        rstn = 1'b0;
        en   = 1'b0;
        #1;
        chk("async_ws", 6, 32'(ws), 32'd0);
        chk("async_bit", 6, 32'(bit_cnt), 32'd0);
        chk("async_fs", 6, 32'(fs), 32'd0);
        chk("async_wl", 6, 32'(wl), 32'd0);
        @(negedge sck);
        #2;
        rstn = 1'b1;
        for (int j = 0; j < 4; j++)
            step(1'b1, 7, pos(j, 1, 1), (j + 1) % 2);

        repeat (4) @(negedge sck);
        chk("cq_drained", 8, 32'(cq.size()), 32'd0);
        chk("wq_drained", 8, 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_ws_gen.md
I2S_TDM_WS_GEN -- requirements
Module: i2s_tdm_ws_gen

Interface
REQ-001 Parameter MAX_SLOTS, default 8, meaning the maximum number of slots per frame, a power of two from 2 to 16.
REQ-002 Parameter SLOT_W, default $clog2(MAX_SLOTS), meaning the width of the slot index.
REQ-003 sck_i  input  1  serial bit clock; the only clock.
REQ-004 rstn_i  input  1  asynchronous, active-low reset.
REQ-005 cfg_en_i  input  1  run enable; generator runs while high.
REQ-006 cfg_mode_i  input  2  WS shape: 0 HALF, 1 PULSE, 2 SLOT, 3 reserved (treated as HALF).
REQ-007 cfg_word_size_i  input  5  bits per slot minus 1 (0..31).
REQ-008 cfg_slots_i  input  SLOT_W  slots per frame minus 1.
REQ-009 cfg_ws_pol_i  input  1  1 = WS active-low (inverts ws_o).
REQ-010 ws_o  output  1  word select / frame sync, updated on the sck_i falling edge.
REQ-011 bit_cnt_o  output  5  current bit index within the slot.
REQ-012 slot_o  output  SLOT_W  current slot index.
REQ-013 frame_start_o  output  1  high during bit 0 of slot 0 while running.
REQ-014 word_last_o  output  1  high during the last bit of any slot while running.

Function
REQ-015 Counters SHALL update on the sck_i rising edge; ws_o SHALL update on the sck_i falling edge.
REQ-016 Shadow config (mode, word size, slots, polarity) SHALL load on every rising edge while stopped, and at the frame wrap while running; cfg changes mid-frame have no effect until the next frame.
REQ-017 Stopped (cfg_en_i=0 at a rising edge): bit_cnt=0, slot=0, frame_start_o=0, word_last_o=0.
REQ-018 Running: bit_cnt SHALL increment by 1; when bit_cnt==word_size it SHALL wrap to 0 and slot SHALL increment; when slot==slots it SHALL also wrap to 0 (frame wrap).
REQ-019 The first rising edge with cfg_en_i=1 after stopped SHALL leave bit_cnt=0, slot=0 (position 0 is held for one bit); counting starts from the following edge.
REQ-020 Define the lookahead position P' as the position the counters hold after the next rising edge; ws_o SHALL be the shaped level of P', so WS leads slot data by one bit (I2S convention).
REQ-021 HALF mode with N=slots+1 >= 2: active iff slot(P') >= N/2 (floor).
REQ-022 HALF mode with N=1: ws_o SHALL toggle at each word boundary, matching the legacy two-channel generator.
REQ-023 PULSE mode: active iff P' is bit 0 of slot 0, giving a one-bit pulse on the last bit of the frame.
REQ-024 SLOT mode: active iff slot(P')==0, giving a long frame sync of one slot width.
REQ-025 ws_o SHALL equal the active level XOR cfg_ws_pol (shadowed value).
REQ-026 While stopped, ws_o SHALL sit at the inactive level (= shadowed polarity), except in HALF mode with N=1, where it SHALL hold the legacy toggle state.
REQ-027 frame_start_o and word_last_o SHALL be decoded combinationally from the registered counters and the running flag, so they have zero latency versus bit_cnt_o and slot_o.
REQ-028 Deassert mid-frame: counters SHALL clear at the next rising edge; ws_o SHALL reach the inactive level at the following falling edge; re-enable restarts at bit 0, slot 0.
REQ-029 word_size=0: every bit is a word_last; with N=1 this SHALL be legal (HALF toggles every bit).
REQ-030 cfg_slots_i values >= MAX_SLOTS are not possible by width; no clamping is needed.

Reset
REQ-031 Asserting rstn_i SHALL asynchronously clear the counters, the running flag, and frame_start_o/word_last_o to 0.
REQ-032 Asserting rstn_i SHALL load the shadow config with 0 (HALF, 1 bit, 1 slot, pol 0) and set ws_o=0.
REQ-033 Reset is valid at any point mid-frame; operation resumes per REQ-019 after release.

Structure
REQ-034 Package i2s_pkg SHALL hold the ws_mode_e enum (WS_HALF, WS_PULSE, WS_SLOT) and the word-size width constant 5.
REQ-035 The block SHALL be a single module with no sub-modules: counters, shadow config, lookahead shaper and falling-edge WS register.

Verification
REQ-036 HALF, slots=1, word_size=15, pol 0 -> ws_o low for 16 bits then high for 16, each edge on the falling edge before bit 0 of the slot; frame_start_o every 32 sck.
REQ-037 PULSE, slots=7, word_size=31 -> ws_o high exactly one sck per 256, covering bit 31 of slot 7; slot_o cycles 0..7.
REQ-038 SLOT, slots=3, word_size=7, pol 1 -> ws_o low for 8 sck, high for 24, repeating every 32.
REQ-039 Change word_size 15->23 at slot 1 bit 5 -> current frame keeps 16-bit slots; the next frame_start begins 24-bit slots.
REQ-040 Drop cfg_en_i at slot 2 bit 9, re-raise after 5 sck -> counters reach 0 at the next rising edge, ws_o goes inactive at the next falling edge, and a clean frame restarts with a one-bit hold.
REQ-041 HALF, slots=0, word_size=0 -> ws_o toggles on every falling edge; word_last_o stays high; async reset mid-run forces ws_o=0 immediately.
